// File: rtl/bg_pkg.sv
// Shared definitions for the background frame scheduler: register map,
// CTRL/STATUS bit positions and the scheduler state encoding.
package bg_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_SEL    = 6'h04;
  localparam logic [5:0] ADDR_PERIOD = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_FCNT   = 6'h10;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_PENDING = 4;
  localparam int STAT_IRQ     = 5;
  localparam int STAT_SEL_ERR = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Slideshow successor: wraps back to layer 0 after the last generator.
  function automatic logic [1:0] next_idx(input logic [1:0] idx, input int num);
    return (idx == 2'(num - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Registers vsync once and emits a single-cycle pulse on its rising edge,
// marking the frame boundary for the scheduler and the scroll logic.
module frame_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic fb
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign fb = vsync & ~vsync_q;

endmodule

// File: rtl/bg_frame_scheduler.sv
// Background layer scheduler: register file plus a frame-synchronous FSM that
// switches layers (manual or slideshow) only on vsync rising edges.
//   state    | meaning
//   ST_IDLE  | video off, no layer enabled
//   ST_START | timing running, first partial frame blanked
//   ST_RUN   | layer displayed, selection applied on each frame boundary
module bg_frame_scheduler
  import bg_pkg::*;
#(
  parameter int NUM_BG   = 2,
  parameter int PERIOD_W = 8,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  input  logic              vsync,
  output logic              vga_en,
  output logic [NUM_BG-1:0] bg_en,
  output logic [1:0]        active_idx,
  output logic              user_interrupt
);

  logic                fb;
  logic                wr_en, sel_wr_ok, sel_wr_bad, irq_clr, sel_err_clr;
  logic                run_q, auto_q, irq_en_q;
  logic                pending_q, irq_q, sel_err_q;
  logic [1:0]          sel_q, idx_nxt;
  logic [PERIOD_W-1:0] period_q, period_eff, countdown_q;
  logic [FCNT_W-1:0]   fcnt_q;
  state_t              state_q;
  logic                unused_in;

  frame_edge_detect u_fed (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (vsync),
    .fb    (fb)
  );

  function automatic logic [NUM_BG-1:0] onehot(input logic [1:0] idx);
    return NUM_BG'(1) << idx;
  endfunction

  assign wr_en       = (data_write_n != 2'b11);
  assign sel_wr_ok   = wr_en && (address == ADDR_SEL) && ({30'b0, data_in[1:0]} < 32'(NUM_BG));
  assign sel_wr_bad  = wr_en && (address == ADDR_SEL) && !sel_wr_ok;
  assign irq_clr     = wr_en && (address == ADDR_STATUS) && data_in[STAT_IRQ];
  assign sel_err_clr = wr_en && (address == ADDR_STATUS) && data_in[STAT_SEL_ERR];
  assign period_eff  = (period_q == '0) ? PERIOD_W'(1) : period_q;

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;
  assign unused_in      = ^{data_read_n, data_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      sel_q     <= '0;
      period_q  <= PERIOD_W'(1);
      sel_err_q <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_CTRL) begin
        run_q    <= data_in[CTRL_RUN];
        auto_q   <= data_in[CTRL_AUTO];
        irq_en_q <= data_in[CTRL_IRQ_EN];
      end
      if (sel_wr_ok) sel_q <= data_in[1:0];
      if (wr_en && address == ADDR_PERIOD) period_q <= data_in[PERIOD_W-1:0];
      if (sel_wr_bad)       sel_err_q <= 1'b1;
      else if (sel_err_clr) sel_err_q <= 1'b0;
    end
  end

  // A pending manual request outranks a slideshow step due on the same frame.
  always_comb begin
    idx_nxt = active_idx;
    if (pending_q)
      idx_nxt = sel_q;
    else if (auto_q && countdown_q == PERIOD_W'(1))
      idx_nxt = next_idx(active_idx, NUM_BG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vga_en      <= 1'b0;
      bg_en       <= '0;
      active_idx  <= '0;
      countdown_q <= '0;
      fcnt_q      <= '0;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (irq_clr) irq_q <= 1'b0;
      if (!run_q) begin
        state_q   <= ST_IDLE;
        vga_en    <= 1'b0;
        bg_en     <= '0;
        pending_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_START;
            vga_en  <= 1'b1;
            bg_en   <= '0;
          end
          ST_START: begin
            if (fb) begin
              state_q     <= ST_RUN;
              countdown_q <= period_eff;
              bg_en       <= onehot(active_idx);
              fcnt_q      <= '0;
            end
          end
          ST_RUN: begin
            if (fb) begin
              fcnt_q     <= fcnt_q + FCNT_W'(1);
              active_idx <= idx_nxt;
              bg_en      <= onehot(idx_nxt);
              pending_q  <= 1'b0;
              if (pending_q || (auto_q && countdown_q == PERIOD_W'(1)))
                countdown_q <= period_eff;
              else if (auto_q)
                countdown_q <= countdown_q - PERIOD_W'(1);
              if (irq_en_q && idx_nxt != active_idx) irq_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
        if (sel_wr_ok) pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_RUN]    = run_q;
        data_out[CTRL_AUTO]   = auto_q;
        data_out[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_SEL:    data_out[1:0] = sel_q;
      ADDR_PERIOD: data_out = 32'(period_q);
      ADDR_STATUS: begin
        data_out[1:0]         = active_idx;
        data_out[STAT_PENDING] = pending_q;
        data_out[STAT_IRQ]     = irq_q;
        data_out[STAT_SEL_ERR] = sel_err_q;
      end
      ADDR_FCNT:   data_out = 32'(fcnt_q);
      default:     data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_bg_frame_scheduler.sv
// Self-checking bench for bg_frame_scheduler: directed scenarios followed by
// randomized register traffic, all checked against a frame-level model.
module tb_bg_frame_scheduler;
  import bg_pkg::*;

  localparam int NUM_BG = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        address;
  logic [31:0]       data_in;
  logic [1:0]        data_write_n;
  logic [1:0]        data_read_n;
  logic [31:0]       data_out;
  logic              data_ready;
  logic              vsync;
  logic              vga_en;
  logic [NUM_BG-1:0] bg_en;
  logic [1:0]        active_idx;
  logic              user_interrupt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bg_frame_scheduler #(.NUM_BG(NUM_BG), .PERIOD_W(8), .FCNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .vsync          (vsync),
    .vga_en         (vga_en),
    .bg_en          (bg_en),
    .active_idx     (active_idx),
    .user_interrupt (user_interrupt)
  );

  // Reference model: video is off / blanking / showing; the slideshow counts
  // frames shown since the last switch against the period captured then.
  bit m_run, m_auto, m_irq_en, m_pending, m_irq, m_sel_err, m_vs_prev;
  int m_mode;
  int m_sel, m_period, m_idx, m_fcnt, m_shown, m_target;

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_auto = 0; m_irq_en = 0; m_pending = 0; m_irq = 0; m_sel_err = 0;
    m_vs_prev = 0; m_mode = 0; m_sel = 0; m_period = 1; m_idx = 0; m_fcnt = 0;
    m_shown = 0; m_target = 1;
  endtask

  task automatic model_step();
    bit wr_en, fb, irq_set;
    int n_idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr_en = (data_write_n != 2'b11);
    fb = vsync && !m_vs_prev;
    m_vs_prev = vsync;
    irq_set = 0;
    if (!m_run) begin
      m_mode = 0;
      m_pending = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (fb) begin
        m_mode = 2; m_fcnt = 0; m_shown = 0; m_target = eff(m_period);
      end
    end else if (fb) begin
      m_fcnt = (m_fcnt + 1) % 65536;
      n_idx = m_idx;
      if (m_pending) begin
        n_idx = m_sel; m_pending = 0; m_shown = 0; m_target = eff(m_period);
      end else if (m_auto) begin
        m_shown++;
        if (m_shown >= m_target) begin
          n_idx = (m_idx + 1) % NUM_BG; m_shown = 0; m_target = eff(m_period);
        end
      end
      if (n_idx != m_idx && m_irq_en) irq_set = 1;
      m_idx = n_idx;
    end
    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          m_run = data_in[0]; m_auto = data_in[1]; m_irq_en = data_in[2];
        end
        ADDR_SEL: begin
          if (int'(data_in[1:0]) < NUM_BG) begin
            m_sel = int'(data_in[1:0]);
            if (m_run) m_pending = 1;
          end else begin
            m_sel_err = 1;
          end
        end
        ADDR_PERIOD: m_period = int'(data_in[7:0]);
        ADDR_STATUS: begin
          if (data_in[5]) m_irq = 0;
          if (data_in[6]) m_sel_err = 0;
        end
        default: ;
      endcase
    end
    if (irq_set) m_irq = 1;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    case (a)
      ADDR_CTRL:   return 32'({m_irq_en, m_auto, m_run});
      ADDR_SEL:    return 32'(m_sel);
      ADDR_PERIOD: return 32'(m_period);
      ADDR_STATUS: return 32'(m_idx) | (32'(m_pending) << 4) | (32'(m_irq) << 5) | (32'(m_sel_err) << 6);
      ADDR_FCNT:   return 32'(m_fcnt);
      default:     return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] exp_bg;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_bg = (m_mode == 2) ? (32'd1 << m_idx) : 32'd0;
    chk("vga_en", 32'(vga_en), 32'(m_mode != 0));
    chk("bg_en", 32'(bg_en), exp_bg);
    chk("active_idx", 32'(active_idx), 32'(m_idx));
    chk("user_interrupt", 32'(user_interrupt), 32'(m_irq));
    chk("bg_onehot", 32'($countones(bg_en) <= 1), 32'd1);
    chk("data_ready", 32'(data_ready), 32'd1);
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; data_write_n = 2'b00;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd_chk(input logic [5:0] a, input string tag);
    address = a; data_write_n = 2'b11;
    #1;
    chk(tag, data_out, model_read(a));
  endtask

  task automatic rd_exp(input logic [5:0] a, input logic [31:0] exp, input string tag);
    address = a; data_write_n = 2'b11;
    #1;
    chk(tag, data_out, exp);
  endtask

  task automatic fb_tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  int seq3 [7] = '{0, 0, 0, 1, 1, 1, 0};
  int irq3 [7] = '{1, 0, 0, 1, 0, 0, 1};
  int seq0 [5] = '{0, 0, 1, 0, 1};
  logic [5:0] rd_addrs [5] = '{ADDR_CTRL, ADDR_SEL, ADDR_PERIOD, ADDR_STATUS, ADDR_FCNT};

  initial begin
    logic [31:0] d;
    logic [5:0]  a;
    int r;
    rst_n = 1'b0; address = '0; data_in = '0; data_write_n = 2'b11;
    data_read_n = 2'b11; vsync = 1'b0;
    model_reset();
    @(negedge clk);
    gap(3);
    chk("rst_vga_en", 32'(vga_en), 32'd0);
    rd_exp(ADDR_PERIOD, 32'd1, "rst_period");
    rst_n = 1'b1;
    gap(2);

    // Start-up: blank partial frame, then layer 0 on first boundary.
    reg_wr(ADDR_CTRL, 32'h1);
    tick();
    chk("t1_vga_en", 32'(vga_en), 32'd1);
    chk("t1_bg_blank", 32'(bg_en), 32'd0);
    gap(3);
    chk("t1_bg_still_blank", 32'(bg_en), 32'd0);
    fb_tick();
    chk("t1_bg_first", 32'(bg_en), 32'b01);
    rd_exp(ADDR_FCNT, 32'd0, "t1_fcnt");

    // Manual select takes effect only at the next boundary.
    gap(3);
    reg_wr(ADDR_SEL, 32'h1);
    chk("t2_bg_hold", 32'(bg_en), 32'b01);
    rd_exp(ADDR_STATUS, 32'h10, "t2_pending");
    gap(2);
    fb_tick();
    chk("t2_bg_sw", 32'(bg_en), 32'b10);
    chk("t2_idx", 32'(active_idx), 32'd1);
    rd_exp(ADDR_STATUS, 32'h01, "t2_status");

    // Slideshow with period 3, interrupts cleared after each frame.
    reg_wr(ADDR_PERIOD, 32'd3);
    reg_wr(ADDR_SEL, 32'd0);
    reg_wr(ADDR_CTRL, 32'h7);
    for (int i = 0; i < 7; i++) begin
      gap(3);
      fb_tick();
      chk("t3_idx", 32'(active_idx), 32'(seq3[i]));
      chk("t3_irq", 32'(user_interrupt), 32'(irq3[i]));
      reg_wr(ADDR_STATUS, 32'h20);
      chk("t3_irq_clr", 32'(user_interrupt), 32'd0);
    end
    reg_wr(ADDR_PERIOD, 32'd0);
    for (int i = 0; i < 5; i++) begin
      gap(3);
      fb_tick();
      chk("t3_p0_idx", 32'(active_idx), 32'(seq0[i]));
      reg_wr(ADDR_STATUS, 32'h20);
    end
    rd_chk(ADDR_FCNT, "t3_fcnt");

    // Out-of-range select.
    reg_wr(ADDR_CTRL, 32'h5);
    reg_wr(ADDR_SEL, 32'd3);
    rd_exp(ADDR_STATUS, 32'h41, "t4_sel_err");
    rd_exp(ADDR_SEL, 32'd0, "t4_sel_kept");
    gap(2);
    fb_tick();
    chk("t4_idx", 32'(active_idx), 32'd1);
    reg_wr(ADDR_STATUS, 32'h40);
    rd_exp(ADDR_STATUS, 32'h01, "t4_sel_err_clr");

    // Manual request meets expiring countdown; irq set beats clear.
    reg_wr(ADDR_PERIOD, 32'd2);
    reg_wr(ADDR_CTRL, 32'h7);
    reg_wr(ADDR_SEL, 32'd1);
    gap(2);
    fb_tick();
    gap(3);
    fb_tick();
    chk("t5_pre_idx", 32'(active_idx), 32'd1);
    reg_wr(ADDR_SEL, 32'd0);
    gap(2);
    vsync = 1'b1; address = ADDR_STATUS; data_in = 32'h20; data_write_n = 2'b10;
    tick();
    vsync = 1'b0; data_write_n = 2'b11;
    chk("t5_idx", 32'(active_idx), 32'd0);
    chk("t5_irq_wins", 32'(user_interrupt), 32'd1);
    reg_wr(ADDR_STATUS, 32'h20);
    gap(3);
    fb_tick();
    chk("t5_reload", 32'(active_idx), 32'd0);
    gap(3);
    fb_tick();
    chk("t5_next", 32'(active_idx), 32'd1);
    reg_wr(ADDR_STATUS, 32'h20);

    // Stop mid-frame, then reset mid-run.
    reg_wr(ADDR_CTRL, 32'h1);
    gap(2);
    reg_wr(ADDR_CTRL, 32'h0);
    tick();
    chk("t6_vga_off", 32'(vga_en), 32'd0);
    chk("t6_bg_off", 32'(bg_en), 32'd0);
    rd_chk(ADDR_FCNT, "t6_fcnt_hold");
    fb_tick();
    rd_chk(ADDR_FCNT, "t6_fcnt_hold2");
    reg_wr(ADDR_PERIOD, 32'd5);
    reg_wr(ADDR_CTRL, 32'h3);
    gap(2);
    fb_tick();
    gap(3);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_vga", 32'(vga_en), 32'd0);
    chk("t6_rst_bg", 32'(bg_en), 32'd0);
    chk("t6_rst_idx", 32'(active_idx), 32'd0);
    chk("t6_rst_irq", 32'(user_interrupt), 32'd0);
    rd_exp(ADDR_PERIOD, 32'd1, "t6_rst_period");
    rd_exp(ADDR_STATUS, 32'd0, "t6_rst_status");
    rst_n = 1'b1;
    tick();

    // Randomized register traffic against the model.
    for (int i = 0; i < 600; i++) begin
      vsync = ((i % 9) < 2);
      data_read_n = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 11);
      d = $urandom;
      case (r)
        0: begin a = ADDR_CTRL; d[0] = ($urandom_range(0, 7) != 0); end
        1: a = ADDR_SEL;
        2: begin a = ADDR_PERIOD; d[7:0] = 8'($urandom_range(0, 3)); end
        3: a = ADDR_STATUS;
        4: a = 6'($urandom_range(0, 63));
        default: a = ADDR_FCNT;
      endcase
      address = a; data_in = d;
      data_write_n = (r <= 4) ? 2'($urandom_range(0, 2)) : 2'b11;
      tick();
      data_write_n = 2'b11;
      if ($urandom_range(0, 5) == 0) rd_chk(6'($urandom_range(0, 63)), "rnd_rd_any");
      else rd_chk(rd_addrs[$urandom_range(0, 4)], "rnd_rd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
